// File: rtl/vlb_regs_pkg.sv
// Shared constants and types for the VLB controller and its host bridge.
package vlb_regs_pkg;

    localparam int VLB_DWIDTH = 32;
    localparam int VLB_AWIDTH = 8;

    // Read-sequencing states of the host bridge.
    typedef enum logic [1:0] {
        VLB_BR_IDLE    = 2'd0,
        VLB_BR_ISSUE   = 2'd1,
        VLB_BR_CAPTURE = 2'd2,
        VLB_BR_RESP    = 2'd3
    } vlb_br_state_e;

    // One queued host request at the default controller widths.
    typedef struct packed {
        logic                  wr;
        logic [VLB_AWIDTH-1:0] addr;
        logic [VLB_DWIDTH-1:0] data;
    } vlb_req_t;

endpackage

// File: rtl/vlb_req_fifo.sv
// In-order request FIFO: registered storage, no bypass, extra pointer bit
// to tell full from empty.
module vlb_req_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign head  = mem[rd_ptr[IW-1:0]];

    // Pointer update; both wrap naturally through the extra MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IW-1:0]] <= push_data;
    end

endmodule

// File: rtl/vlb_host_bridge.sv
// Host-side front end for the VLB memory controller: queues valid/ready
// requests, issues single-cycle controller strobes in order, sequences
// reads through a small FSM and keeps saturating access counters.
//
// state   | meaning
// IDLE    | no read in flight; head read may pop
// ISSUE   | read strobe on the controller pins
// CAPTURE | controller data_out valid; sampled at end of cycle
// RESP    | rsp_valid high, waiting for rsp_ready
module vlb_host_bridge
    import vlb_regs_pkg::*;
#(
    parameter int DWIDTH     = VLB_DWIDTH,
    parameter int AWIDTH     = VLB_AWIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [AWIDTH-1:0]    req_addr,
    input  logic [DWIDTH-1:0]    req_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [AWIDTH-1:0]    rsp_addr,
    output logic [DWIDTH-1:0]    rsp_data,
    output logic                 wr_rd_valid,
    output logic                 wr_rd,
    output logic [AWIDTH-1:0]    addr,
    output logic [DWIDTH-1:0]    data_in,
    input  logic [DWIDTH-1:0]    data_out,
    output logic [CNT_WIDTH-1:0] wr_cnt,
    output logic [CNT_WIDTH-1:0] rd_cnt
);

    localparam int REQ_W = 1 + AWIDTH + DWIDTH;

    vlb_br_state_e     state;
    vlb_br_state_e     state_next;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              read_pop;
    logic              write_pop;
    logic              rsp_hs;
    logic [REQ_W-1:0]  push_data;
    logic [REQ_W-1:0]  head;
    logic              head_wr;
    logic [AWIDTH-1:0] head_addr;
    logic [DWIDTH-1:0] head_data;

    assign push_data = {req_wr, req_addr, req_data};
    assign head_wr   = head[REQ_W-1];
    assign head_addr = head[REQ_W-2 -: AWIDTH];
    assign head_data = head[DWIDTH-1:0];

    // Gated by rst_n so nothing is accepted during the reset cycle itself.
    assign req_ready = rst_n && !fifo_full;
    assign push      = req_valid && req_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;

    vlb_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= VLB_BR_IDLE;
        else        state <= state_next;
    end

    // Pop decision and next state. A head read waits for IDLE, which keeps
    // every later request (writes included) behind it.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        read_pop   = 1'b0;
        write_pop  = 1'b0;

        if (!fifo_empty) begin
            if (head_wr) begin
                pop       = 1'b1;
                write_pop = 1'b1;
            end else if (state == VLB_BR_IDLE) begin
                pop      = 1'b1;
                read_pop = 1'b1;
            end
        end

        case (state)
            VLB_BR_IDLE:    if (read_pop) state_next = VLB_BR_ISSUE;
            VLB_BR_ISSUE:   state_next = VLB_BR_CAPTURE;
            VLB_BR_CAPTURE: state_next = VLB_BR_RESP;
            VLB_BR_RESP:    if (rsp_ready) state_next = VLB_BR_IDLE;
            default:        state_next = VLB_BR_IDLE;
        endcase
    end

    // Controller strobe: one cycle after each pop; address/data/direction
    // hold their last values between strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_rd_valid <= 1'b0;
            wr_rd       <= 1'b0;
            addr        <= '0;
            data_in     <= '0;
        end else begin
            wr_rd_valid <= pop;
            if (pop) begin
                wr_rd   <= head_wr;
                addr    <= head_addr;
                data_in <= head_data;
            end
        end
    end

    // Response channel: address latched at pop, data sampled in CAPTURE,
    // valid registered straight from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= (state_next == VLB_BR_RESP);
            if (read_pop)                  rsp_addr <= head_addr;
            if (state == VLB_BR_CAPTURE)   rsp_data <= data_out;
        end
    end

    // Saturating access counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (write_pop && (wr_cnt != '1)) wr_cnt <= wr_cnt + CNT_WIDTH'(1);
            if (rsp_hs && (rd_cnt != '1))    rd_cnt <= rd_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_vlb_host_bridge.sv
// Self-checking bench for vlb_host_bridge with a stand-in controller memory
// and an in-order transaction-level reference model.
module tb_vlb_host_bridge;
    import vlb_regs_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          wr_rd_valid;
    logic          wr_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;

    int n_tests = 0;
    int n_fails = 0;

    vlb_host_bridge #(
        .DWIDTH     (DW),
        .AWIDTH     (AW),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_addr    (rsp_addr),
        .rsp_data    (rsp_data),
        .wr_rd_valid (wr_rd_valid),
        .wr_rd       (wr_rd),
        .addr        (addr),
        .data_in     (data_in),
        .data_out    (data_out),
        .wr_cnt      (wr_cnt),
        .rd_cnt      (rd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    // Stand-in controller: memory with a registered read port.
    logic [DW-1:0] ctrl_mem [256];
    bit            ctrl_init = 1'b0;
    always @(posedge clk) begin
        if (!ctrl_init) begin
            for (int i = 0; i < 256; i++) ctrl_mem[i] <= '0;
            data_out  <= '0;
            ctrl_init <= 1'b1;
        end else if (wr_rd_valid) begin
            if (wr_rd) ctrl_mem[addr] <= data_in;
            else       data_out       <= ctrl_mem[addr];
        end
    end

    // Stimulus driver.
    vlb_req_t drv_q[$];
    bit       gap_mode      = 1'b0;
    bit       rsp_mode      = 1'b0;
    bit       rsp_ready_set = 1'b0;
    always @(posedge clk) begin
        #1;
        if (drv_q.size() > 0 && (!gap_mode || $urandom_range(0, 2) != 0)) begin
            req_valid = 1'b1;
            req_wr    = drv_q[0].wr;
            req_addr  = drv_q[0].addr;
            req_data  = drv_q[0].data;
        end else begin
            req_valid = 1'b0;
        end
        rsp_ready = rsp_mode ? 1'($urandom_range(0, 1)) : rsp_ready_set;
    end

    // Reference model: requests retire in acceptance order; a read returns
    // the last value written to its address by any earlier request.
    vlb_req_t      exp_q[$];
    rsp_t          rsp_q[$];
    int            wr_cyc_q[$];
    logic [DW-1:0] ref_mem [256];
    bit            ref_init      = 1'b0;
    int            cyc           = 0;
    int            pushes        = 0;
    int            pops          = 0;
    int            wr_pops       = 0;
    int            hs            = 0;
    int            rd_strobe_cyc = -100;
    int            last_hs_cyc   = -100;
    bit            rd_busy       = 1'b0;
    bit            prev_stall    = 1'b0;
    bit            prev_rsp_v    = 1'b0;
    bit            saw_full      = 1'b0;
    logic [AW-1:0] last_rd_addr  = '0;
    vlb_req_t      e;
    rsp_t          r;
    int            occ;

    always @(negedge clk) begin
        cyc++;
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = '0;
            ref_init = 1'b1;
        end
        if (!rst_n) begin
            check_val("ready_in_reset", 64'(req_ready), 64'd0);
            exp_q.delete();
            rsp_q.delete();
            pushes = 0; pops = 0; wr_pops = 0; hs = 0;
            rd_busy = 1'b0; prev_stall = 1'b0; prev_rsp_v = 1'b0;
        end else begin
            if (wr_rd_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("strobe_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    check_val("strobe_dir", 64'(wr_rd), 64'(e.wr));
                    check_val("strobe_addr", 64'(addr), 64'(e.addr));
                    if (e.wr) begin
                        check_val("strobe_data", 64'(data_in), 64'(e.data));
                        wr_pops++;
                        wr_cyc_q.push_back(cyc);
                    end else begin
                        check_val("read_overlap", 64'(rd_busy), 64'd0);
                        check_val("read_after_hs", 64'(cyc > last_hs_cyc + 1), 64'd1);
                        rd_busy       = 1'b1;
                        rd_strobe_cyc = cyc;
                        last_rd_addr  = addr;
                    end
                end
            end
            if (prev_stall) check_val("rsp_hold", 64'(rsp_valid), 64'd1);
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check_val("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    check_val("rsp_addr", 64'(rsp_addr), 64'(rsp_q[0].addr));
                    check_val("rsp_data", 64'(rsp_data), 64'(rsp_q[0].data));
                end
                if (!prev_rsp_v) check_val("rsp_latency", 64'(cyc - rd_strobe_cyc), 64'd2);
            end
            check_val("wr_cnt", 64'(wr_cnt), 64'(sat(wr_pops)));
            check_val("rd_cnt", 64'(rd_cnt), 64'(sat(hs)));
            occ = pushes - pops;
            check_val("req_ready", 64'(req_ready), 64'(occ < DEPTH));
            if (!req_ready) saw_full = 1'b1;
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() > 0) void'(rsp_q.pop_front());
                hs++;
                last_hs_cyc = cyc;
                rd_busy     = 1'b0;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_rsp_v = rsp_valid;
            if (req_valid && req_ready) begin
                e.wr   = req_wr;
                e.addr = req_addr;
                e.data = req_data;
                exp_q.push_back(e);
                pushes++;
                if (req_wr) begin
                    ref_mem[req_addr] = req_data;
                end else begin
                    r.addr = req_addr;
                    r.data = ref_mem[req_addr];
                    rsp_q.push_back(r);
                end
                if (drv_q.size() > 0) void'(drv_q.pop_front());
            end
        end
    end

    task automatic enq(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        vlb_req_t q;
        q.wr = wr; q.addr = a; q.data = d;
        drv_q.push_back(q);
    endtask

    task automatic wait_rsp(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
        end
        check_val(tag, 64'(found), 64'd1);
    endtask

    task automatic wait_rd_strobe(input logic [AW-1:0] a, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk); #1;
            if (rd_busy && last_rd_addr == a) found = 1'b1;
        end
        check_val(tag, 64'(found), 64'd1);
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clk); #1;
            if (drv_q.size() == 0 && exp_q.size() == 0 && rsp_q.size() == 0 && !rsp_valid)
                done = 1'b1;
        end
        check_val(tag, 64'(done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] held;

    initial begin
        rst_n = 1'b0;
        // Reset and idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_wr_rd_valid", 64'(wr_rd_valid), 64'd0);
        check_val("rst_wr_rd", 64'(wr_rd), 64'd0);
        check_val("rst_addr", 64'(addr), 64'd0);
        check_val("rst_data_in", 64'(data_in), 64'd0);
        check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("rst_rsp_addr", 64'(rsp_addr), 64'd0);
        check_val("rst_rsp_data", 64'(rsp_data), 64'd0);
        check_val("rst_wr_cnt", 64'(wr_cnt), 64'd0);
        check_val("rst_rd_cnt", 64'(rd_cnt), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("ready_after_rst", 64'(req_ready), 64'd1);
        repeat (5) @(negedge clk);
        check_val("idle_no_strobe", 64'(wr_rd_valid), 64'd0);

        // Write then read back the same address.
        rsp_ready_set = 1'b1;
        enq(1'b1, 8'h10, 32'hDEADBEEF);
        enq(1'b0, 8'h10, 32'h0);
        wait_rsp("wr_rd_rsp_seen");
        check_val("wr_rd_rsp_addr", 64'(rsp_addr), 64'h10);
        check_val("wr_rd_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
        @(negedge clk);
        check_val("wr_rd_wr_cnt", 64'(wr_cnt), 64'd1);
        check_val("wr_rd_rd_cnt", 64'(rd_cnt), 64'd1);
        drain("drain_basic");

        // Fill the FIFO behind a stalled read.
        rsp_ready_set = 1'b0;
        enq(1'b0, 8'h20, 32'h0);
        wait_rsp("stall_rsp_seen");
        saw_full = 1'b0;
        enq(1'b0, 8'h21, 32'h0);
        for (int i = 0; i < 5; i++) enq(1'b1, 8'(8'h50 + i), 32'hA000_0000 + 32'(i));
        repeat (12) @(negedge clk);
        #1;
        check_val("fifo_full_seen", 64'(saw_full), 64'd1);
        check_val("fifo_blocked", 64'(exp_q.size()), 64'd4);
        check_val("drv_waiting", 64'(drv_q.size()), 64'd2);
        wr_cyc_q.delete();
        rsp_ready_set = 1'b1;
        drain("drain_full");
        check_val("burst_writes", 64'(wr_cyc_q.size()), 64'd5);
        if (wr_cyc_q.size() == 5)
            check_val("burst_rate", 64'(wr_cyc_q[4] - wr_cyc_q[0]), 64'd4);

        // Long response stall, then a queued read.
        rsp_ready_set = 1'b0;
        enq(1'b0, 8'h30, 32'h0);
        enq(1'b0, 8'h31, 32'h0);
        wait_rsp("hold_rsp_seen");
        held = rsp_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("hold_valid", 64'(rsp_valid), 64'd1);
            check_val("hold_data", 64'(rsp_data), 64'(held));
        end
        rsp_ready_set = 1'b1;
        wait_rd_strobe(8'h31, "second_read_seen");
        check_val("second_read_cycle", 64'(rd_strobe_cyc - last_hs_cyc), 64'd2);
        drain("drain_hold");

        // Reset while a read is in CAPTURE with three reads queued.
        rsp_ready_set = 1'b0;
        for (int i = 0; i < 5; i++) enq(1'b0, 8'(8'h40 + i), 32'h0);
        wait_rsp("rst_rsp_seen");
        rsp_ready_set = 1'b1;
        @(negedge clk);
        rsp_ready_set = 1'b0;
        wait_rd_strobe(8'h41, "rst_read_seen");
        check_val("rst_queued", 64'(exp_q.size()), 64'd3);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("mid_rst_wr_cnt", 64'(wr_cnt), 64'd0);
        check_val("mid_rst_rd_cnt", 64'(rd_cnt), 64'd0);
        check_val("mid_rst_ready", 64'(req_ready), 64'd1);
        check_val("mid_rst_strobe", 64'(wr_rd_valid), 64'd0);
        rsp_ready_set = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("no_late_rsp", 64'(rsp_valid), 64'd0);
            check_val("no_late_strobe", 64'(wr_rd_valid), 64'd0);
        end

        // Write counter saturation.
        for (int i = 0; i < 17; i++) enq(1'b1, 8'(8'h60 + i), $urandom);
        drain("drain_sat");
        check_val("wr_cnt_sat", 64'(wr_cnt), 64'(CMAX));

        // Randomized traffic with request gaps and response back-pressure.
        gap_mode = 1'b1;
        rsp_mode = 1'b1;
        for (int i = 0; i < 200; i++)
            enq(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
        drain("drain_random");
        gap_mode = 1'b0;
        rsp_mode = 1'b0;
        rsp_ready_set = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/vlb_host_bridge.md
Name: vlb_host_bridge

Overview:
- Request-side front end for the VLB memory controller (vlb_dut); sits directly upstream and drives its data_in/wr_rd/wr_rd_valid/addr pins.
- Consumes its registered data_out.
- Converts a valid/ready request stream into single-cycle controller accesses, using a small in-order request FIFO.
- Returns read data on a valid/ready response channel; keeps saturating access counters.

Parameters:
- DWIDTH, 32, data width; must match the controller.
- AWIDTH, 8, address width; must match the controller.
- FIFO_DEPTH, 4, request FIFO entries; power of 2, ≥2.
- CNT_WIDTH, 16, width of the access statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- req_valid  in  1  request offered
- req_ready  out  1  FIFO can accept a request
- req_wr  in  1  1=write, 0=read
- req_addr  in  AWIDTH  request address
- req_data  in  DWIDTH  write data; ignored for reads
- rsp_valid  out  1  read response available
- rsp_ready  in  1  consumer accepts response
- rsp_addr  out  AWIDTH  address of the returned read
- rsp_data  out  DWIDTH  read data
- wr_rd_valid  out  1  access strobe to controller
- wr_rd  out  1  access direction to controller
- addr  out  AWIDTH  access address to controller
- data_in  out  DWIDTH  write data to controller
- data_out  in  DWIDTH  controller read data; valid the cycle after a read strobe
- wr_cnt  out  CNT_WIDTH  writes issued, saturating
- rd_cnt  out  CNT_WIDTH  reads completed (response handshaken), saturating

Behaviour:
- Reset (rst_n=0 at posedge): FIFO emptied; FSM→IDLE; counters 0. All registered outputs 0: wr_rd_valid, wr_rd, addr, data_in, rsp_valid, rsp_addr, rsp_data. req_ready is 0 while rst_n=0. Reset mid-operation discards queued and in-flight requests; no response is produced.
- Request FIFO:
  - req_ready = !full.
  - Push on req_valid && req_ready.
  - No write-through bypass; a pushed entry is poppable from the next cycle.
  - Simultaneous push and pop is legal when not full; occupancy is unchanged.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Issue stage:
  - At most one pop per cycle, strictly in order.
  - Head write: popped whenever the FIFO is non-empty.
  - Head read: popped only when the FSM is IDLE.
  - A blocked head read stalls everything behind it (no reordering).
  - Pop in cycle P → wr_rd_valid=1 with wr_rd/addr/data_in registered, during cycle P+1 only.
  - With no pop, wr_rd_valid=0. addr, data_in and wr_rd hold their last values.
  - Back-to-back writes reach 1 per cycle.
- Read FSM (states IDLE, ISSUE, CAPTURE, RESP):
  - IDLE→ISSUE on a read pop at end of P. Latch head address into rsp_addr.
  - ISSUE (cycle P+1, strobe on pins) → CAPTURE.
  - CAPTURE (cycle P+2): sample data_out into rsp_data at end of cycle → RESP.
  - RESP: rsp_valid=1, rsp_data/rsp_addr held stable. → IDLE on rsp_ready.
  - A read can pop in the same cycle the FSM returns to IDLE? No: the pop condition uses the current state. With rsp_ready tied high, reads issue every 4 cycles.
  - Writes behind a read may issue during ISSUE/CAPTURE/RESP. The read has already sampled the controller, so order is preserved.
- Counters:
  - wr_cnt increments on each write pop.
  - rd_cnt increments on each rsp handshake.
  - Both saturate at all-ones (no wrap).
- Widths: no arithmetic on data; all counter/pointer adds are unsigned with explicit width.

Decomposition:
- Shared constants stay in vlb_regs_pkg.
- Add to that package: an enum for FSM states (VLB_BR_IDLE, VLB_BR_ISSUE, VLB_BR_CAPTURE, VLB_BR_RESP) and a packed request struct (wr, addr, data).
- One sub-module: vlb_req_fifo. Parameterised on width/depth; synchronous active-low reset; push/pop/full/empty/head.
- The bridge holds the issue logic, FSM and counters.

Test Plan:
- Reset then idle → all outputs 0; req_ready=1 one cycle after rst_n rises; wr_rd_valid never asserts.
- Write 0xDEADBEEF to 0x10, then read 0x10, rsp_ready=1 → wr_rd_valid pulses twice.
  - Write pulse: wr_rd=1, data_in=0xDEADBEEF.
  - Read pulse: wr_rd=0.
  - rsp_valid 2 cycles after the read strobe: rsp_addr=0x10, rsp_data=0xDEADBEEF.
  - wr_cnt=1, rd_cnt=1.
- Push 5 writes back-to-back (FIFO_DEPTH=4) while a read to 0x20 is stalled in RESP (rsp_ready=0) → req_ready drops when full; queued writes still issue 1/cycle behind the read; no request lost.
- Read 0x30 with rsp_ready held 0 for 10 cycles, then a queued read 0x31 → second read strobe not issued until the cycle after the 0x30 handshake; rsp_data for 0x30 stable all 10 cycles.
- Assert rst_n=0 during CAPTURE with 3 entries queued → next cycle: rsp_valid=0, FSM IDLE, FIFO empty, counters 0; no late response after reset release.
- Force wr_cnt near max (CNT_WIDTH=4, 17 writes) → wr_cnt sticks at 0xF.
